mips32_prog_loader: RTL and testbench

Boot-time program loader placed directly upstream of the pipelined MIPS32 core. It receives a framed byte stream, packs it into 32-bit words, writes them into the core's instruction/data memory from address 0, and checks an XOR checksum. On a good checksum it releases the core from reset and counts run cycles until the core reports HALTED. This replaces testbench-side preloading of memory with a synthesizable load path.

---
 rtl/mips32_loader_pkg.sv | 17 +
 rtl/mips32_byte_packer.sv | 31 +++
 rtl/mips32_prog_loader.sv | 138 +++++++++++++
 tb/tb_mips32_prog_loader.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips32_loader_pkg.sv
// Shared types and constants for the MIPS32 boot loader.
// No logic; imported by the loader top and its byte packer.
package mips32_loader_pkg;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_LOAD,
        ST_CSUM,
        ST_RUN,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam int          BYTES_PER_WORD = 4;
    localparam logic [31:0] RUN_CYCLES_SAT = 32'hFFFF_FFFF;

endpackage

// File: rtl/mips32_byte_packer.sv
// Packs accepted bytes big-endian into 32-bit words; word/word_done are combinational
// in the cycle the 4th byte is taken, so consumers act on that same edge. Never stalls.
module mips32_byte_packer
    import mips32_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_take,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_done,
    output logic [1:0]  byte_cnt
);

    logic [23:0] partial;

    assign word      = {partial, byte_data};
    assign word_done = byte_take && (byte_cnt == 2'(BYTES_PER_WORD - 1));

    // The counter wraps 3 -> 0 by itself, so a completed word needs no explicit clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt <= '0;
            partial  <= '0;
        end else if (byte_take) begin
            byte_cnt <= byte_cnt + 2'd1;
            partial  <= {partial[15:0], byte_data};
        end
    end

endmodule

// File: rtl/mips32_prog_loader.sv
// Loads a framed byte stream (length, words, XOR checksum) into core memory, then runs the core.
// One write per word, registered one cycle after its 4th byte; accepts a byte every cycle while loading.
module mips32_prog_loader
    import mips32_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    input  logic              cpu_halted,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       run_cycles
);

    localparam logic [31:0]   MAX_WORDS = 32'(1) << ADDR_W;
    localparam logic [ADDR_W:0] ONE_W   = 1;

    state_t              state, state_nxt;
    logic [31:0]         word;
    logic                word_done;
    logic [1:0]          byte_cnt;
    logic                take;
    logic [ADDR_W-1:0]   idx;
    logic [ADDR_W:0]     n_words;
    logic [31:0]         acc;
    logic                hdr_bad, csum_ok, last_word;

    assign take      = in_valid && in_ready;
    assign hdr_bad   = (word == 32'd0) || (word > MAX_WORDS);
    assign csum_ok   = (word == acc);
    // Compare one bit wider so a full 2^ADDR_W program ends at all-ones without wrapping.
    assign last_word = ({1'b0, idx} == (n_words - ONE_W));

    mips32_byte_packer u_packer (
        .clk       (clk1),
        .rst       (rst),
        .byte_take (take),
        .byte_data (in_data),
        .word      (word),
        .word_done (word_done),
        .byte_cnt  (byte_cnt)
    );

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) state <= ST_HDR;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        cpu_reset = 1'b1;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            ST_HDR: begin
                in_ready = !rst;
                busy     = (byte_cnt != 2'd0);
                if (word_done) state_nxt = hdr_bad ? ST_ERR : ST_LOAD;
            end
            ST_LOAD: begin
                in_ready = !rst;
                busy     = 1'b1;
                if (word_done && last_word) state_nxt = ST_CSUM;
            end
            ST_CSUM: begin
                in_ready = !rst;
                busy     = 1'b1;
                if (word_done) state_nxt = csum_ok ? ST_RUN : ST_ERR;
            end
            ST_RUN: begin
                cpu_reset = 1'b0;
                if (cpu_halted) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                cpu_reset = 1'b0;
                done      = 1'b1;
            end
            ST_ERR: begin
                err = 1'b1;
            end
            default: state_nxt = ST_HDR;
        endcase
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            idx        <= '0;
            n_words    <= '0;
            acc        <= '0;
            run_cycles <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                ST_HDR: begin
                    if (word_done) begin
                        n_words <= word[ADDR_W:0];
                        idx     <= '0;
                        acc     <= '0;
                    end
                end
                ST_LOAD: begin
                    if (word_done) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= idx;
                        mem_wdata <= word;
                        acc       <= acc ^ word;
                        if (!last_word) idx <= idx + ADDR_W'(1);
                    end
                end
                ST_CSUM: begin
                    // The first RUN cycle already counts as one.
                    if (word_done && csum_ok) run_cycles <= 32'd1;
                end
                ST_RUN: begin
                    // The halting cycle was counted on entry to it, so hold on halt.
                    if (!cpu_halted && run_cycles != RUN_CYCLES_SAT)
                        run_cycles <= run_cycles + 32'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Directed bench for mips32_prog_loader: frame-level model checked every cycle plus literal checks.
module tb_mips32_prog_loader;

    localparam int P_HDR = 0, P_LOAD = 1, P_CSUM = 2, P_RUN = 3, P_DONE = 4, P_ERR = 5;

    logic        clk1 = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset;
    logic        cpu_halted = 1'b0;
    logic        busy, done, err;
    logic [31:0] run_cycles;

    int n_checks = 0;
    int n_fail = 0;

    mips32_prog_loader #(.ADDR_W(10)) dut (
        .clk1       (clk1),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_reset  (cpu_reset),
        .cpu_halted (cpu_halted),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .run_cycles (run_cycles)
    );

    always #5 clk1 = ~clk1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: parses the accepted byte stream into header, words and checksum.
    int          ph, nb, widx;
    logic [31:0] cur, nwords, xacc, mcyc;
    logic        exp_we;
    logic [9:0]  exp_addr;
    logic [31:0] exp_dat;

    always @(posedge clk1) begin
        exp_we = 1'b0;
        if (rst) begin
            ph = P_HDR; nb = 0; cur = 0; widx = 0; xacc = 0; mcyc = 0; nwords = 0;
        end else if (ph <= P_CSUM) begin
            if (in_valid) begin
                cur = {cur[23:0], in_data};
                nb++;
                if (nb == 4) begin
                    nb = 0;
                    if (ph == P_HDR) begin
                        if (cur == 0 || cur > 1024) ph = P_ERR;
                        else begin nwords = cur; widx = 0; xacc = 0; ph = P_LOAD; end
                    end else if (ph == P_LOAD) begin
                        exp_we = 1'b1; exp_addr = 10'(widx); exp_dat = cur;
                        xacc ^= cur;
                        widx++;
                        if (widx == int'(nwords)) ph = P_CSUM;
                    end else begin
                        if (cur == xacc) begin ph = P_RUN; mcyc = 1; end
                        else ph = P_ERR;
                    end
                end
            end
        end else if (ph == P_RUN) begin
            if (cpu_halted) ph = P_DONE;
            else if (mcyc != 32'hFFFF_FFFF) mcyc++;
        end
    end

    always @(negedge clk1) begin
        if (rst) begin
            chk("rst_in_ready", 32'(in_ready), 0);
            chk("rst_mem_we", 32'(mem_we), 0);
            chk("rst_mem_addr", 32'(mem_addr), 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_cpu_reset", 32'(cpu_reset), 1);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_err", 32'(err), 0);
            chk("rst_run_cycles", run_cycles, 0);
        end else begin
            chk("in_ready", 32'(in_ready), 32'(ph <= P_CSUM));
            chk("cpu_reset", 32'(cpu_reset), 32'(!(ph == P_RUN || ph == P_DONE)));
            chk("busy", 32'(busy), 32'((ph == P_HDR && nb != 0) || ph == P_LOAD || ph == P_CSUM));
            chk("done", 32'(done), 32'(ph == P_DONE));
            chk("err", 32'(err), 32'(ph == P_ERR));
            chk("run_cycles", run_cycles, mcyc);
            chk("mem_we", 32'(mem_we), 32'(exp_we));
            if (exp_we) begin
                chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
                chk("mem_wdata", mem_wdata, exp_dat);
            end
        end
    end

    logic [9:0]  log_addr[$];
    logic [31:0] log_dat[$];

    always @(negedge clk1) begin
        if (!rst && mem_we) begin
            log_addr.push_back(mem_addr);
            log_dat.push_back(mem_wdata);
        end
    end

    logic [31:0] prog [1024];

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        logic r;
        if (gaps && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            repeat ($urandom_range(1, 2)) @(posedge clk1);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk1);
            r = in_ready;
            @(posedge clk1);
            #1;
            if (r) return;
        end
        chk("byte_accept_timeout", 0, 1);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], gaps);
    endtask

    task automatic send_frame(input int n, input bit bad_csum, input bit gaps);
        logic [31:0] x;
        x = 0;
        send_word(32'(n), gaps);
        for (int i = 0; i < n; i++) begin
            send_word(prog[i], gaps);
            x ^= prog[i];
        end
        send_word(bad_csum ? (x ^ 32'd1) : x, gaps);
        in_valid = 1'b0;
    endtask

    task automatic check_log(input int n);
        chk("write_count", 32'(log_addr.size()), 32'(n));
        for (int i = 0; i < log_addr.size() && i < n; i++) begin
            chk("log_addr", 32'(log_addr[i]), 32'(i));
            chk("log_data", log_dat[i], prog[i]);
        end
    endtask

    task automatic reset_pulse();
        @(posedge clk1);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        cpu_halted = 1'b0;
        repeat (2) @(posedge clk1);
        #1;
        log_addr.delete();
        log_dat.delete();
        rst = 1'b0;
        #1;
        chk("ready_after_release", 32'(in_ready), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk1);
        #1;
        rst = 1'b0;
        #1;
        chk("ready_after_release", 32'(in_ready), 1);

        // Good two-word frame, then halt in the 20th RUN cycle.
        prog[0] = 32'h2801_000a;
        prog[1] = 32'h2802_0014;
        send_frame(2, 1'b0, 1'b0);
        check_log(2);
        chk("t1_cpu_reset", 32'(cpu_reset), 0);
        chk("t1_first_run_cycle", run_cycles, 1);
        repeat (19) @(posedge clk1);
        #1;
        cpu_halted = 1'b1;
        @(posedge clk1);
        #1;
        cpu_halted = 1'b0;
        chk("t1_done", 32'(done), 1);
        chk("t1_run_cycles", run_cycles, 20);
        repeat (3) @(posedge clk1);
        #1;
        chk("t1_frozen", run_cycles, 20);

        // Same frame, checksum 0x0003001f.
        reset_pulse();
        send_frame(2, 1'b1, 1'b0);
        @(posedge clk1);
        #1;
        check_log(2);
        chk("t2_err", 32'(err), 1);
        chk("t2_cpu_reset", 32'(cpu_reset), 1);
        chk("t2_in_ready", 32'(in_ready), 0);

        // Zero-length header, with cpu_halted held high (must be ignored).
        reset_pulse();
        cpu_halted = 1'b1;
        send_word(32'd0, 1'b0);
        in_valid = 1'b0;
        @(posedge clk1);
        #1;
        cpu_halted = 1'b0;
        chk("t3_err", 32'(err), 1);
        chk("t3_done", 32'(done), 0);
        chk("t3_writes", 32'(log_addr.size()), 0);

        // One word too many.
        reset_pulse();
        send_word(32'd1025, 1'b0);
        in_valid = 1'b0;
        #1;
        chk("t4_err", 32'(err), 1);

        // Nine words with random valid gaps.
        reset_pulse();
        for (int i = 0; i < 9; i++) prog[i] = 32'h0102_0304 * (i + 1) ^ 32'hA5A5_0000;
        send_frame(9, 1'b0, 1'b1);
        check_log(9);
        chk("t5_cpu_reset", 32'(cpu_reset), 0);

        // Largest program: last address must be all-ones.
        reset_pulse();
        for (int i = 0; i < 1024; i++) prog[i] = 32'h9E37_79B9 * i + 32'd7;
        send_frame(1024, 1'b0, 1'b0);
        check_log(1024);
        if (log_addr.size() > 0) chk("t6_last_addr", 32'(log_addr[log_addr.size()-1]), 32'h3FF);
        chk("t6_cpu_reset", 32'(cpu_reset), 0);

        // Reset six bytes into LOAD, then a fresh one-word frame.
        reset_pulse();
        send_word(32'd2, 1'b0);
        send_word(32'h1122_3344, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        in_valid = 1'b0;
        reset_pulse();
        prog[0] = 32'hDEAD_BEEF;
        send_frame(1, 1'b0, 1'b0);
        check_log(1);
        chk("t7_cpu_reset", 32'(cpu_reset), 0);
        chk("t7_err", 32'(err), 0);

        // Saturation: preload the counter just below all-ones.
        force dut.run_cycles = 32'hFFFF_FFFC;
        mcyc = 32'hFFFF_FFFC;
        #1;
        release dut.run_cycles;
        repeat (6) @(posedge clk1);
        #1;
        chk("t8_saturated", run_cycles, 32'hFFFF_FFFF);
        chk("t8_not_done", 32'(done), 0);
        cpu_halted = 1'b1;
        @(posedge clk1);
        #1;
        cpu_halted = 1'b0;
        chk("t8_done", 32'(done), 1);
        chk("t8_held", run_cycles, 32'hFFFF_FFFF);

        repeat (2) @(posedge clk1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
